// File: rtl/xor_stream_decoder_if.sv
// Valid/ready stream carrying W-bit data; used for both the ciphertext input
// and the plaintext output of the XOR stream decoder.
interface xor_stream_decoder_if #(
  parameter int unsigned W = 4
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/xor_stream_decoder.sv
// Receive-side stream decoder: XORs each ciphertext word with an 8-bit Fibonacci
// LFSR keystream and presents the plaintext through a one-deep output register.
module xor_stream_decoder #(
  parameter int unsigned W    = 4,
  parameter logic [7:0]  SEED = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [7:0]            seed_i,
  xor_stream_decoder_if.slave   in_if,
  xor_stream_decoder_if.master  out_if,
  output logic [7:0]            count_o
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e       state_q, state_d;
  logic [7:0]   lfsr_q, lfsr_d;
  logic [7:0]   count_q, count_d;
  logic [W-1:0] data_q, data_d;
  logic         lfsr_fb;
  logic         accept;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Ready does not look at valid so the source may wait on it.
  assign in_if.ready = !load_i && ((state_q == StEmpty) || out_if.ready);
  assign accept      = in_if.valid && in_if.ready;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    count_d = count_q;
    data_d  = data_q;
    if (load_i) begin
      // An all-zero seed would lock the LFSR, so fall back to the reset seed.
      lfsr_d  = (seed_i == 8'h00) ? SEED : seed_i;
      count_d = 8'h00;
      state_d = StEmpty;
    end else begin
      if (accept) begin
        data_d  = in_if.data ^ lfsr_q[W-1:0];
        lfsr_d  = {lfsr_q[6:0], lfsr_fb};
        count_d = count_q + 8'd1;
      end
      unique case (state_q)
        StEmpty: begin
          if (accept) state_d = StFull;
        end
        StFull: begin
          if (out_if.ready && !accept) state_d = StEmpty;
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      lfsr_q  <= SEED;
      count_q <= 8'h00;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign out_if.valid = (state_q == StFull);
  assign out_if.data  = data_q;
  assign count_o      = count_q;

endmodule

// File: tb/tb_xor_stream_decoder.sv
// Randomised and directed bench for xor_stream_decoder, checked against a
// transaction-level model built from a keystream generator and an output queue.
module tb_xor_stream_decoder;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] seed;
  logic [7:0] count;

  xor_stream_decoder_if #(.W(4)) in_if ();
  xor_stream_decoder_if #(.W(4)) out_if ();

  xor_stream_decoder #(
    .W    (4),
    .SEED (8'hA5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .seed_i  (seed),
    .in_if   (in_if),
    .out_if  (out_if),
    .count_o (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_bad;

  // Reference model: keystream state, decoded-word tally, pending outputs.
  logic [7:0] m_lfsr;
  int unsigned m_cnt;
  logic [3:0] exp_q[$];

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic [7:0] taps;
    taps = s & 8'hB8;
    return {s[6:0], ^taps};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_lfsr = 8'hA5;
    m_cnt  = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic iv, input logic [3:0] d, input logic ordy, input logic ld,
                      input logic [7:0] sd, output logic acc, output logic popped,
                      output logic [3:0] pv);
    logic exp_rdy;
    in_if.valid   = iv;
    in_if.data    = d;
    out_if.ready  = ordy;
    load          = ld;
    seed          = sd;
    #1;
    exp_rdy = !ld && (exp_q.size() == 0 || ordy);
    check_eq("in_ready", {31'd0, in_if.ready}, {31'd0, exp_rdy});
    check_eq("out_valid", {31'd0, out_if.valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) check_eq("out_data", {28'd0, out_if.data}, {28'd0, exp_q[0]});
    acc    = iv && exp_rdy;
    popped = (exp_q.size() != 0) && ordy && !ld;
    pv     = out_if.data;
    @(posedge clk);
    if (ld) begin
      exp_q.delete();
      m_lfsr = (sd == 8'h00) ? 8'hA5 : sd;
      m_cnt  = 0;
    end else begin
      if (popped) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(d ^ m_lfsr[3:0]);
        m_lfsr = lfsr_step(m_lfsr);
        m_cnt  = m_cnt + 1;
      end
    end
    @(negedge clk);
    check_eq("count", {24'd0, count}, m_cnt % 256);
  endtask

  logic       a, p;
  logic [3:0] v;
  logic [7:0] tx_lfsr;
  logic [3:0] pt, ct;
  logic [3:0] rt_q[$];
  int unsigned sent, cyc;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    load  = 1'b0;
    seed  = 8'h00;
    in_if.valid  = 1'b0;
    in_if.data   = 4'h0;
    out_if.ready = 1'b0;
    model_reset();
    #1;
    check_eq("rst_in_ready", {31'd0, in_if.ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_if.valid}, 32'd0);
    check_eq("rst_out_data", {28'd0, out_if.data}, 32'd0);
    check_eq("rst_count", {24'd0, count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back decode after reset.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'hF, 1'b1, 1'b0, 8'h00, a, p, v);
      if (i == 0) check_eq("first_after_reset", {28'd0, out_if.data}, 32'hA);
      if (i == 1) check_eq("second_after_reset", {28'd0, out_if.data}, 32'h5);
    end
    step(1'b0, 4'h0, 1'b1, 1'b0, 8'h00, a, p, v);
    check_eq("count_three", {24'd0, count}, 32'd3);

    // Back-pressure: output held, no key consumed while stalled.
    step(1'b0, 4'h0, 1'b1, 1'b1, 8'hA5, a, p, v);
    step(1'b1, 4'hF, 1'b1, 1'b0, 8'h00, a, p, v);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'hF, 1'b0, 1'b0, 8'h00, a, p, v);
      check_eq("bp_hold_data", {28'd0, out_if.data}, 32'hA);
    end
    step(1'b1, 4'hF, 1'b1, 1'b0, 8'h00, a, p, v);
    check_eq("bp_passthrough", {28'd0, out_if.data}, 32'h5);
    step(1'b0, 4'h0, 1'b1, 1'b0, 8'h00, a, p, v);

    // Load while full discards the pending word.
    step(1'b1, 4'hF, 1'b0, 1'b0, 8'h00, a, p, v);
    step(1'b1, 4'hF, 1'b0, 1'b1, 8'h4A, a, p, v);
    check_eq("load_accept_blocked", {31'd0, a}, 32'd0);
    check_eq("load_clears_valid", {31'd0, out_if.valid}, 32'd0);
    step(1'b1, 4'hF, 1'b1, 1'b0, 8'h00, a, p, v);
    check_eq("load_4a_decode", {28'd0, out_if.data}, 32'h5);

    // Zero seed falls back to A5.
    step(1'b0, 4'h0, 1'b1, 1'b1, 8'h00, a, p, v);
    step(1'b1, 4'hF, 1'b1, 1'b0, 8'h00, a, p, v);
    check_eq("load_zero_decode", {28'd0, out_if.data}, 32'hA);

    // Round trip with random gaps on both sides.
    step(1'b0, 4'h0, 1'b1, 1'b1, 8'hA5, a, p, v);
    tx_lfsr = 8'hA5;
    sent = 0;
    cyc  = 0;
    pt   = 4'($urandom_range(0, 15));
    while ((sent < 300 || rt_q.size() != 0) && cyc < 5000) begin
      ct = pt ^ tx_lfsr[3:0];
      step((sent < 300) && ($urandom_range(0, 3) != 0), ct, $urandom_range(0, 2) != 0,
           1'b0, 8'h00, a, p, v);
      if (p && rt_q.size() != 0) check_eq("rt_plain", {28'd0, v}, {28'd0, rt_q.pop_front()});
      if (a) begin
        rt_q.push_back(pt);
        tx_lfsr = lfsr_step(tx_lfsr);
        sent++;
        pt = 4'($urandom_range(0, 15));
      end
      cyc++;
    end
    check_eq("rt_finished", {31'd0, cyc < 5000}, 32'd1);
    check_eq("rt_count_wrap", {24'd0, count}, 32'd44);

    // Asynchronous reset while full.
    step(1'b1, 4'hF, 1'b0, 1'b0, 8'h00, a, p, v);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'd0, out_if.valid}, 32'd0);
    check_eq("async_rst_count", {24'd0, count}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'hF, 1'b1, 1'b0, 8'h00, a, p, v);
    check_eq("post_rst_decode", {28'd0, out_if.data}, 32'hA);
    step(1'b0, 4'h0, 1'b1, 1'b0, 8'h00, a, p, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
